cache_arbiter: RTL and testbench
================================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 The block SHALL have one parameter: LINE_W, default 256, cache line width in bits for all line-wide data ports.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 i_pmem_read  input  1  I-cache line-read request.
REQ-005 i_pmem_address  input  32  I-cache line address.
REQ-006 i_pmem_resp  output  1  I-cache transaction complete.
REQ-007 i_pmem_rdata  output  LINE_W  I-cache read line.
REQ-008 d_pmem_read  input  1  D-cache line-read request.
REQ-009 d_pmem_write  input  1  D-cache line-writeback request.
REQ-010 d_pmem_address  input  32  D-cache line address.
REQ-011 d_pmem_wdata  input  LINE_W  D-cache writeback line.
REQ-012 d_pmem_resp  output  1  D-cache transaction complete.
REQ-013 d_pmem_rdata  output  LINE_W  D-cache read line.
REQ-014 pmem_read  output  1  physical memory read strobe.
REQ-015 pmem_write  output  1  physical memory write strobe.
REQ-016 pmem_address  output  32  physical memory address.
REQ-017 pmem_wdata  output  LINE_W  physical memory write line.
REQ-018 pmem_resp  input  1  physical memory transaction complete.
REQ-019 pmem_rdata  input  LINE_W  physical memory read line.

Function
REQ-020 The block SHALL implement an FSM with states IDLE, SERVE_I, SERVE_D, plus a 1-bit last_grant register (0=I, 1=D).
REQ-021 In IDLE, with only I requesting: next state SERVE_I; only D requesting (read or write): next state SERVE_D; neither: stay IDLE.
REQ-022 In IDLE, with both requesting: grant the side not equal to last_grant (round-robin); last_grant SHALL update to the granted side on every grant.
REQ-023 On the IDLE->SERVE_x edge, the block SHALL latch the granted address, the op (read/write) and, for D writes, wdata into internal registers; requester input changes during SERVE SHALL be ignored.
REQ-024 d_pmem_read and d_pmem_write asserted together SHALL be treated as a write.
REQ-025 pmem_read/pmem_write SHALL be driven from registered state only: asserted for every cycle of SERVE_x per the latched op, 0 in IDLE; never both 1.
REQ-026 pmem_address and pmem_wdata SHALL come from the latched registers; pmem_wdata SHALL be ignored for reads.
REQ-027 In SERVE_x, the cycle pmem_resp=1 SHALL assert x_pmem_resp combinationally in the same cycle, and the FSM SHALL return to IDLE on that edge.
REQ-028 The non-granted side's resp SHALL be 0 at all times; both *_pmem_rdata SHALL pass through pmem_rdata unmodified.
REQ-029 Latency: a request first visible in IDLE at cycle N SHALL produce the pmem strobe at cycle N+1; one IDLE cycle SHALL separate back-to-back grants.
REQ-030 pmem_resp while in IDLE SHALL be ignored (no resp, no state change).
REQ-031 A requester dropping its request mid-SERVE SHALL NOT abort the transaction; it completes on pmem_resp.
REQ-032 A requester whose request drops before grant SHALL NOT be granted.

Reset
REQ-033 On rst=1, asynchronously: state=IDLE, last_grant=1 (D), latched address/wdata/op=0; all outputs SHALL be 0 except rdata passthroughs.
REQ-034 rst asserted mid-SERVE SHALL abort the transaction with no resp issued; after release, pending requests SHALL be re-arbitrated from IDLE.

Verification
REQ-035 I read 0x0000_1000 alone, memory resp after 3 cycles -> pmem_read=1 with address 0x0000_1000 from cycle N+1; i_pmem_resp=1 for exactly one cycle coincident with pmem_resp; rdata matches.
REQ-036 I read and D write requested together first after reset -> I served first (last_grant=1); then D: pmem_write=1, pmem_wdata equals D line; one IDLE cycle between.
REQ-037 Both request continuously for 4 transactions -> grants alternate I, D, I, D.
REQ-038 D read 0x0000_2000 granted, then d_pmem_address changed to 0x0000_3000 mid-SERVE -> pmem_address stays 0x0000_2000 until resp.
REQ-039 rst pulsed during SERVE_D before pmem_resp -> pmem_read/pmem_write=0 immediately, d_pmem_resp never asserts; after release the still-pending D request is re-granted.
REQ-040 Spurious pmem_resp in IDLE, plus d_pmem_read and d_pmem_write asserted together -> no resp or state change in IDLE; the combined request is issued as pmem_write=1, pmem_read=0.

Source files
------------

// File: rtl/cache_arbiter.sv
// Two-port round-robin arbiter sharing one physical memory port between the
// I-cache (read only) and the D-cache (read/writeback).
//
// state   | meaning
// IDLE    | no transaction in flight; arbitrate pending requests
// SERVE_I | I-cache line read issued to memory, waiting for pmem_resp
// SERVE_D | D-cache read or writeback issued to memory, waiting for pmem_resp
module cache_arbiter #(
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_pmem_read,
  input  logic [31:0]       i_pmem_address,
  output logic              i_pmem_resp,
  output logic [LINE_W-1:0] i_pmem_rdata,

  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [31:0]       d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic              d_pmem_resp,
  output logic [LINE_W-1:0] d_pmem_rdata,

  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              last_grant;
  logic [31:0]       lat_addr;
  logic [LINE_W-1:0] lat_wdata;
  logic              lat_write;

  logic i_req;
  logic d_req;
  logic grant_d;
  logic serving;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

  // On contention the side that did not win last time gets the port.
  assign grant_d = (i_req & d_req) ? ~last_grant : d_req;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (i_req | d_req) state_nxt = grant_d ? SERVE_D : SERVE_I;
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_write  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && (i_req | d_req)) begin
        last_grant <= grant_d;
        lat_addr   <= grant_d ? d_pmem_address : i_pmem_address;
        // A simultaneous D read+write strobe is a writeback.
        lat_write  <= grant_d & d_pmem_write;
        if (grant_d & d_pmem_write) lat_wdata <= d_pmem_wdata;
      end
    end
  end

  assign serving      = (state == SERVE_I) | (state == SERVE_D);
  assign pmem_read    = serving & ~lat_write;
  assign pmem_write   = serving & lat_write;
  assign pmem_address = lat_addr;
  assign pmem_wdata   = lat_wdata;

  assign i_pmem_resp  = (state == SERVE_I) & pmem_resp;
  assign d_pmem_resp  = (state == SERVE_D) & pmem_resp;
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios followed by
// randomized traffic, checked against a round-robin transaction model.
module tb_cache_arbiter;
  localparam int LINE_W = 256;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_pmem_read = 1'b0;
  logic [31:0]       i_pmem_address = '0;
  logic              i_pmem_resp;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              d_pmem_read = 1'b0;
  logic              d_pmem_write = 1'b0;
  logic [31:0]       d_pmem_address = '0;
  logic [LINE_W-1:0] d_pmem_wdata = '0;
  logic              d_pmem_resp;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              pmem_read;
  logic              pmem_write;
  logic [31:0]       pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic              pmem_resp = 1'b0;
  logic [LINE_W-1:0] pmem_rdata = '0;

  int checks = 0;
  int errors = 0;
  // Model: which side won the most recent grant (1 = D), reset value D.
  bit model_last = 1'b1;

  always #5 clk = ~clk;

  cache_arbiter #(.LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_resp(i_pmem_resp), .i_pmem_rdata(i_pmem_rdata),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_resp(d_pmem_resp), .d_pmem_rdata(d_pmem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] r;
    for (int k = 0; k < LINE_W / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle in which the DUT must be idle; new requester inputs are applied.
  task automatic idle_step(input bit ir, input bit dr, input bit dw,
                           input logic [31:0] ia, input logic [31:0] da,
                           input logic [LINE_W-1:0] wd, input bit spur);
    @(negedge clk);
    i_pmem_read = ir; d_pmem_read = dr; d_pmem_write = dw;
    i_pmem_address = ia; d_pmem_address = da; d_pmem_wdata = wd;
    pmem_resp = spur; pmem_rdata = rand_line();
    #1;
    chk("idle_pmem_read", pmem_read, 0);
    chk("idle_pmem_write", pmem_write, 0);
    chk("idle_i_resp", i_pmem_resp, 0);
    chk("idle_d_resp", d_pmem_resp, 0);
  endtask

  // Follows one granted transaction: lat strobe-only cycles, then the resp cycle.
  task automatic serve(input bit ed, input bit ew, input logic [31:0] ea,
                       input logic [LINE_W-1:0] ewd, input int lat, input bit scr);
    @(posedge clk);
    model_last = ed;
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      if (scr) begin
        i_pmem_read = 1'($urandom); d_pmem_read = 1'($urandom); d_pmem_write = 1'($urandom);
        i_pmem_address = $urandom; d_pmem_address = 32'h0000_3000;
        d_pmem_wdata = rand_line();
      end
      pmem_resp = (k == lat);
      pmem_rdata = rand_line();
      #1;
      chk("serve_pmem_read", pmem_read, !ew);
      chk("serve_pmem_write", pmem_write, ew);
      chk("serve_pmem_address", pmem_address, ea);
      if (ew) chk("serve_pmem_wdata", pmem_wdata, ewd);
      chk("serve_i_resp", i_pmem_resp, (k == lat) && !ed);
      chk("serve_d_resp", d_pmem_resp, (k == lat) && ed);
      chk("i_rdata_pass", i_pmem_rdata, pmem_rdata);
      chk("d_rdata_pass", d_pmem_rdata, pmem_rdata);
    end
    @(posedge clk);
  endtask

  task automatic txn(input bit ir, input bit dr, input bit dw,
                     input logic [31:0] ia, input logic [31:0] da,
                     input logic [LINE_W-1:0] wd, input int lat, input bit scr, input bit spur);
    bit ed;
    bit ew;
    idle_step(ir, dr, dw, ia, da, wd, spur);
    ed = (ir && (dr || dw)) ? !model_last : (dr || dw);
    ew = ed && dw;
    serve(ed, ew, ed ? da : ia, wd, lat, scr);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    i_pmem_read = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0; pmem_resp = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_last = 1'b1;
  endtask

  initial begin
    logic [LINE_W-1:0] wd;
    logic [2:0] r;

    pmem_rdata = rand_line();
    #1;
    chk("rst_pmem_read", pmem_read, 0);
    chk("rst_pmem_write", pmem_write, 0);
    chk("rst_pmem_address", pmem_address, 0);
    chk("rst_pmem_wdata", pmem_wdata, 0);
    chk("rst_i_resp", i_pmem_resp, 0);
    chk("rst_d_resp", d_pmem_resp, 0);
    chk("rst_i_rdata", i_pmem_rdata, pmem_rdata);
    chk("rst_d_rdata", d_pmem_rdata, pmem_rdata);
    @(negedge clk);
    rst = 1'b0;

    // I read alone, memory answers after three strobe cycles
    txn(1, 0, 0, 32'h0000_1000, 32'h0, '0, 3, 0, 0);

    // Contention straight after reset, I first then D writeback
    reset_pulse();
    wd = rand_line();
    txn(1, 0, 1, 32'h0000_1100, 32'h0000_2200, wd, 1, 0, 0);
    txn(1, 0, 1, 32'h0000_1100, 32'h0000_2200, wd, 2, 0, 0);

    // Continuous contention alternates
    for (int t = 0; t < 4; t++)
      txn(1, 1, 0, $urandom, $urandom, rand_line(), t, 0, 0);

    // D read address must hold while requester inputs change
    txn(0, 1, 0, 32'h0, 32'h0000_2000, '0, 3, 1, 0);

    // Spurious resp in IDLE, then combined D read+write is a write
    idle_step(0, 0, 0, $urandom, $urandom, rand_line(), 1);
    idle_step(0, 0, 0, $urandom, $urandom, rand_line(), 1);
    wd = rand_line();
    txn(0, 1, 1, 32'h0, 32'h0000_4000, wd, 1, 0, 1);

    // Reset in the middle of a D transaction
    wd = rand_line();
    idle_step(0, 1, 1, 32'h0, 32'h0000_5000, wd, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("pre_rst_pmem_write", pmem_write, 1);
    rst = 1'b1;
    pmem_resp = 1'b1;
    #1;
    chk("abort_pmem_read", pmem_read, 0);
    chk("abort_pmem_write", pmem_write, 0);
    chk("abort_d_resp", d_pmem_resp, 0);
    chk("abort_i_resp", i_pmem_resp, 0);
    chk("abort_pmem_address", pmem_address, 0);
    @(negedge clk);
    rst = 1'b0;
    pmem_resp = 1'b0;
    model_last = 1'b1;
    #1;
    chk("post_rst_pmem_write", pmem_write, 0);
    chk("post_rst_d_resp", d_pmem_resp, 0);
    serve(1, 1, 32'h0000_5000, wd, 2, 0);

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 2) == 0)
        idle_step(0, 0, 0, $urandom, $urandom, rand_line(), 1'($urandom));
      r = 3'($urandom_range(1, 7));
      txn(r[0], r[1], r[2], $urandom, $urandom, rand_line(),
          $urandom_range(0, 3), 1'($urandom), 1'($urandom));
    end

    idle_step(0, 0, 0, '0, '0, '0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
